booth_mul_iter: RTL
===================

// Module: booth_mul_iter
// PURPOSE
//  Iterative radix-4 Booth multiplier for the integer datapath (MULT/MULTU).
//  Replaces the all-at-once partial-product generator with a parametrised engine.
//  Each cycle it Booth-encodes DIGITS_PER_CYCLE multiplier digits and accumulates
//  them into a 2*WIDTH product, with a signed/unsigned mode.
//  It connects to the execute stage through valid/ready handshakes on both sides,
//  and a flush input lets the pipeline cancel an operation in flight.
// PARAMETERS
//  WIDTH             32  operand width; must be even and >= 4
//  DIGITS_PER_CYCLE  2   Booth digits accumulated per CALC cycle; range 1..NDIG
//  (derived) NDIG = WIDTH/2+1 Booth digits; NCYC = ceil(NDIG/DIGITS_PER_CYCLE)
// PORTS
//  clk        in   1        clock, rising edge
//  resetn     in   1        asynchronous active-low reset
//  in_valid   in   1        operands present
//  in_ready   out  1        engine can accept operands (high only in IDLE)
//  is_signed  in   1        1: two's-complement operands; 0: unsigned
//  src_a      in   WIDTH    multiplicand
//  src_b      in   WIDTH    multiplier
//  flush      in   1        abort current operation; discard result
//  out_valid  out  1        product valid; held until taken
//  out_ready  in   1        consumer takes product
//  prod_hi    out  WIDTH    product[2*WIDTH-1:WIDTH]
//  prod_lo    out  WIDTH    product[WIDTH-1:0]
//  busy       out  1        state != IDLE
// BEHAVIOUR
//  Reset (async, resetn=0): state=IDLE, in_ready=1, out_valid=0, busy=0, prod_hi/lo=0, count=0.
//  FSM states are IDLE, CALC and DONE.
//   IDLE->CALC on in_valid&&in_ready&&!flush: latch operands, clear accumulator, count=0.
//   CALC: each edge adds min(DIGITS_PER_CYCLE, NDIG-count) partial products; count advances.
//   CALC->DONE on the edge that consumes the last digit. out_valid is high from then on.
//   DONE->IDLE on out_valid&&out_ready. prod_hi/lo keep their value until the next accept.
//   flush=1 in any state: ->IDLE on the next edge, out_valid=0, no product delivered.
//  Latency: out_valid rises exactly NCYC edges after the accepting edge.
//   With the defaults that is 9 edges. There is no back-to-back accept, because in_ready=0 in DONE.
//  Operand extension: both operands extend to WIDTH+2 bits, by sign when is_signed=1 and by zero otherwise.
//   Digit i uses triplet b_ext[2i+1:2i-1], with b_ext[-1]=0.
//  Booth encoding of each digit:
//   000 or 111 -> 0
//   001 or 010 -> +A
//   011 -> +2A
//   100 -> -2A
//   101 or 110 -> -A
//   Each partial product is sign-extended to 2*WIDTH bits and shifted left by 2i.
//  Result width: the product is exact modulo 2^(2*WIDTH) for every operand pair, in both modes.
//  Inputs src_a, src_b and is_signed are sampled only at accept; later changes are ignored.
//  Simultaneous events:
//   flush together with in_valid in IDLE -> not accepted.
//   flush together with out_ready in DONE -> ->IDLE (same end state).
//  If resetn is asserted mid-CALC, all state clears immediately; the next accept starts fresh.
// TESTING
//  T1 signed:   A=0xFFFFFFFF, B=0xFFFFFFFF -> hi=0x00000000, lo=0x00000001, 9 edges after accept.
//  T2 unsigned: A=0xFFFFFFFF, B=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
//  T3 signed:   A=0x80000000, B=0x80000000 -> hi=0x40000000, lo=0x0.
//     signed:   A=0x80000000, B=1 -> hi=0xFFFFFFFF, lo=0x80000000.
//  T4 backpressure: out_ready=0 for 5 cycles after out_valid -> out_valid, hi and lo stable.
//     in_ready stays 0 until the handshake, then returns to 1 on the next edge.
//  T5 flush on the 4th CALC cycle -> next edge IDLE, out_valid never rises.
//     A following accept of 7*6 (signed) -> hi=0, lo=42.
//  T6 resetn low mid-CALC, then a random sweep of 10k pairs in both modes for
//     DIGITS_PER_CYCLE in {1,2,17} -> all outputs match reset values, and every product
//     matches the reference model with latency NCYC.

Source files
------------

// File: rtl/booth_mul_iter.sv
// booth_mul_iter: iterative radix-4 Booth multiplier with signed/unsigned mode.
// Each CALC cycle accumulates DIGITS_PER_CYCLE Booth partial products into a
// 2*WIDTH accumulator. Operands enter and the product leaves through valid/ready
// handshakes, and flush cancels the operation in flight.
module booth_mul_iter #(
    parameter int WIDTH            = 32,
    parameter int DIGITS_PER_CYCLE = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] prod_hi,
    output logic [WIDTH-1:0] prod_lo,
    output logic             busy
);

    localparam int NDIG = WIDTH / 2 + 1;
    localparam int PW   = 2 * WIDTH;
    localparam int BW   = WIDTH + 3;     // b_ext[WIDTH+1:-1]
    localparam int CW   = $clog2(NDIG + DIGITS_PER_CYCLE + 1) + 1;
    localparam int STEP = 2 * DIGITS_PER_CYCLE;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          state_r;
    logic [CW-1:0]   count_r;
    logic [PW-1:0]   acc_r;
    logic [PW-1:0]   mcand_r;    // multiplicand, pre-shifted to the current digit group
    logic [BW-1:0]   mplier_r;   // multiplier triplet window, shifted right per cycle
    logic            in_ready_r;
    logic            out_valid_r;
    logic            busy_r;
    logic [WIDTH-1:0] prod_hi_r;
    logic [WIDTH-1:0] prod_lo_r;

    logic [PW-1:0]   acc_next_s;
    logic            last_s;
    logic            a_sign_s;
    logic            b_sign_s;

    // Booth-recode one triplet into a signed multiple of the multiplicand.
    function automatic logic [PW-1:0] booth_pp(input logic [2:0] trip,
                                               input logic [PW-1:0] mc);
        logic [PW-1:0] pp;
        case (trip)
            3'b000:  pp = {PW{1'b0}};
            3'b001:  pp = mc;
            3'b010:  pp = mc;
            3'b011:  pp = mc << 1;
            3'b100:  pp = {PW{1'b0}} - (mc << 1);
            3'b101:  pp = {PW{1'b0}} - mc;
            3'b110:  pp = {PW{1'b0}} - mc;
            3'b111:  pp = {PW{1'b0}};
            default: pp = {PW{1'b0}};
        endcase
        return pp;
    endfunction

    // Operand sign bits used for extension; zero in unsigned mode.
    always_comb begin
        a_sign_s = is_signed & src_a[WIDTH-1];
        b_sign_s = is_signed & src_b[WIDTH-1];
    end

    // Sum this cycle's partial products; digits past NDIG contribute nothing.
    always_comb begin
        acc_next_s = acc_r;
        for (int k = 0; k < DIGITS_PER_CYCLE; k++) begin
            if (int'(count_r) + k < NDIG) begin
                acc_next_s = acc_next_s + (booth_pp(mplier_r[2*k +: 3], mcand_r) << (2 * k));
            end else begin
                acc_next_s = acc_next_s;
            end
        end
        last_s = (int'(count_r) + DIGITS_PER_CYCLE >= NDIG);
    end

    // Control FSM, datapath registers and registered handshake outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r     <= ST_IDLE;
            count_r     <= {CW{1'b0}};
            acc_r       <= {PW{1'b0}};
            mcand_r     <= {PW{1'b0}};
            mplier_r    <= {BW{1'b0}};
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            prod_hi_r   <= {WIDTH{1'b0}};
            prod_lo_r   <= {WIDTH{1'b0}};
        end else if (flush) begin
            // Cancel whatever is in flight; the last delivered product stays visible.
            state_r     <= ST_IDLE;
            count_r     <= {CW{1'b0}};
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid && in_ready_r) begin
                        state_r    <= ST_CALC;
                        count_r    <= {CW{1'b0}};
                        acc_r      <= {PW{1'b0}};
                        mcand_r    <= {{WIDTH{a_sign_s}}, src_a};
                        mplier_r   <= {b_sign_s, b_sign_s, src_b, 1'b0};
                        in_ready_r <= 1'b0;
                        busy_r     <= 1'b1;
                    end
                end
                ST_CALC: begin
                    acc_r    <= acc_next_s;
                    count_r  <= count_r + CW'(DIGITS_PER_CYCLE);
                    mcand_r  <= mcand_r << STEP;
                    mplier_r <= mplier_r >> STEP;
                    if (last_s) begin
                        state_r     <= ST_DONE;
                        out_valid_r <= 1'b1;
                        prod_hi_r   <= acc_next_s[PW-1:WIDTH];
                        prod_lo_r   <= acc_next_s[WIDTH-1:0];
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_r     <= ST_IDLE;
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        busy_r      <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    count_r     <= {CW{1'b0}};
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign prod_hi   = prod_hi_r;
    assign prod_lo   = prod_lo_r;

endmodule
